// File: rtl/result_bus_arbiter.sv
// Picks up to BUS_COUNT ready reservation stations per cycle and drives their results onto registered bus lanes.
// Defining RESULT_BUS_ROUND_ROBIN_EN makes the search start rotate; without it the lowest index always wins.
module result_bus_arbiter #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [STATION_COUNT-1:0]                station_ready,
  input  logic [SIZE*STATION_COUNT-1:0]           station_result,
  output logic [STATION_COUNT-1:0]                station_release,
  output logic [BUS_COUNT-1:0]                    bus_asserted,
  output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
  output logic [SIZE*BUS_COUNT-1:0]               bus_value
);

  logic [STATION_COUNT-1:0]                release_q, release_d;
  logic [BUS_COUNT-1:0]                    asserted_q, asserted_d;
  logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] source_q, source_d;
  logic [SIZE*BUS_COUNT-1:0]               value_q, value_d;
  logic [STATION_COUNT-1:0]                eligible;
  logic [STATION_INDEX_SIZE-1:0]           ptr;

`ifdef RESULT_BUS_ROUND_ROBIN_EN
  logic [STATION_INDEX_SIZE-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // A station released this cycle still shows ready until the next edge.
  assign eligible = station_ready & ~release_q;

  always_comb begin
    int                            idx;
    int                            lane;
    logic [STATION_INDEX_SIZE-1:0] idx_s;
    release_d  = '0;
    asserted_d = '0;
    source_d   = '0;
    value_d    = '0;
`ifdef RESULT_BUS_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    lane       = 0;
    idx        = 0;
    idx_s      = '0;
    for (int j = 0; j < STATION_COUNT; j++) begin
      idx = int'(ptr) + j;
      if (idx >= STATION_COUNT) begin
        idx = idx - STATION_COUNT;
      end
      idx_s = STATION_INDEX_SIZE'(idx);
      if (eligible[idx_s] && (lane < BUS_COUNT)) begin
        asserted_d[lane]                                        = 1'b1;
        source_d[lane*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] = idx_s;
        value_d[lane*SIZE +: SIZE]                              = station_result[idx*SIZE +: SIZE];
        release_d[idx_s]                                        = 1'b1;
        lane                                                    = lane + 1;
`ifdef RESULT_BUS_ROUND_ROBIN_EN
        // Later grants overwrite, leaving the pointer just past the last one.
        ptr_d = ((idx + 1) >= STATION_COUNT) ? '0 : STATION_INDEX_SIZE'(idx + 1);
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      release_q  <= '0;
      asserted_q <= '0;
      source_q   <= '0;
      value_q    <= '0;
    end else begin
      release_q  <= release_d;
      asserted_q <= asserted_d;
      source_q   <= source_d;
      value_q    <= value_d;
    end
  end

`ifdef RESULT_BUS_ROUND_ROBIN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign station_release = release_q;
  assign bus_asserted    = asserted_q;
  assign bus_source      = source_q;
  assign bus_value       = value_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Closed-loop bench: a station model dispatches work, a reference model queues expected bus cycles, a monitor compares.
module tb_result_bus_arbiter;
  localparam int SIZE = 32;
  localparam int SC   = 4;
  localparam int SIS  = 2;
  localparam int BC   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [SC-1:0]       station_ready;
  logic [SIZE*SC-1:0]  station_result;
  logic [SC-1:0]       station_release;
  logic [BC-1:0]       bus_asserted;
  logic [SIS*BC-1:0]   bus_source;
  logic [SIZE*BC-1:0]  bus_value;

  always #5 clock = ~clock;

  result_bus_arbiter #(
    .SIZE(SIZE), .STATION_COUNT(SC), .STATION_INDEX_SIZE(SIS), .BUS_COUNT(BC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .station_ready(station_ready),
    .station_result(station_result),
    .station_release(station_release),
    .bus_asserted(bus_asserted),
    .bus_source(bus_source),
    .bus_value(bus_value)
  );

  typedef struct {
    logic [BC-1:0]      asrt;
    logic [SIS*BC-1:0]  src;
    logic [SIZE*BC-1:0] val;
    logic [SC-1:0]      rel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Station model: occupancy, held result and the result loaded by a pending dispatch.
  logic [SC-1:0]   occ      = '0;
  logic [SC-1:0]   set_prev = '0;
  logic [SC-1:0]   rel_a    = '0;
  logic [SC-1:0]   rel_b    = '0;
  logic [SIZE-1:0] res[SC];
  logic [SIZE-1:0] pend[SC];
  int              p_model  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic [SC-1:0] disp_in, input logic [SC-1:0] redisp,
                       input logic rnd, input logic [SIZE-1:0] val);
    logic [SC-1:0] disp;
    logic [SC-1:0] elig;
    logic [SC-1:0] rel_c;
    exp_t          e;
    int            granted[$];
    int            idx;
    @(negedge clock);
    for (int i = 0; i < SC; i++) begin
      if (set_prev[i]) begin
        occ[i] = 1'b1;
        res[i] = pend[i];
      end else if (rel_a[i]) begin
        occ[i] = 1'b0;
      end
    end
    disp = (disp_in | (redisp & rel_b)) & (~occ | rel_b);
    for (int i = 0; i < SC; i++) begin
      if (disp[i]) pend[i] = rnd ? SIZE'($urandom) : val;
    end
    reset         = rst;
    station_ready = occ;
    for (int i = 0; i < SC; i++) station_result[i*SIZE +: SIZE] = res[i];

    e     = '{default: '0};
    rel_c = '0;
    if (rst) begin
      p_model = 0;
    end else begin
      elig = occ & ~rel_b;
      for (int k = 0; k < SC; k++) begin
        idx = (p_model + k) % SC;
        if (elig[idx]) granted.push_back(idx);
      end
      for (int g = 0; g < granted.size() && g < BC; g++) begin
        e.asrt[g]               = 1'b1;
        e.src[g*SIS +: SIS]     = SIS'(granted[g]);
        e.val[g*SIZE +: SIZE]   = res[granted[g]];
        rel_c[granted[g]]       = 1'b1;
`ifdef RESULT_BUS_ROUND_ROBIN_EN
        p_model = (granted[g] + 1) % SC;
`endif
      end
    end
    e.rel = rel_c;
    exp_q.push_back(e);
    rel_a    = rel_b;
    rel_b    = rel_c;
    set_prev = disp;
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("bus_asserted",    64'(bus_asserted),    64'(mon_e.asrt));
      check("bus_source",      64'(bus_source),      64'(mon_e.src));
      check("bus_value",       64'(bus_value),       64'(mon_e.val));
      check("station_release", 64'(station_release), 64'(mon_e.rel));
    end
  end

  initial begin
    reset          = 1'b1;
    station_ready  = '0;
    station_result = '0;
    for (int i = 0; i < SC; i++) begin
      res[i]  = '0;
      pend[i] = '0;
    end

    // Reset held with every station ready, then drain.
    cycle(1'b1, 4'b1111, '0, 1'b1, '0);
    cycle(1'b1, '0, '0, 1'b1, '0);
    cycle(1'b1, '0, '0, 1'b1, '0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, '0);

    // Single station with a fixed result.
    cycle(1'b0, 4'b0100, '0, 1'b0, 32'hDEADBEEF);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, '0);

    // Stations 0 and 3 after the pointer sits at 3.
    cycle(1'b0, 4'b1001, '0, 1'b1, '0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, '0);

    // Three stations competing for two lanes.
    cycle(1'b0, 4'b1110, '0, 1'b1, '0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, '0);

    // Stations 0,1,3 re-dispatched as soon as released.
    cycle(1'b0, 4'b1011, '0, 1'b1, '0);
    repeat (12) cycle(1'b0, '0, 4'b1011, 1'b1, '0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, '0);

    // Reset lands on the cycle station 1 is on the bus.
    cycle(1'b0, 4'b0010, '0, 1'b0, 32'h12345678);
    cycle(1'b0, '0, '0, 1'b1, '0);
    cycle(1'b1, '0, '0, 1'b1, '0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, '0);

    // Random dispatch traffic with occasional resets.
    repeat (500) cycle(($urandom_range(0, 39) == 0), SC'($urandom), '0, 1'b1, '0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, '0);

    @(posedge clock);
    #2;
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Drives the common result buses from the reservation stations. Each cycle it selects up to BUS_COUNT ready stations, broadcasts their results on registered bus lanes tagged with the station index, and pulses a per-station release that frees the station. It sits between the station array (result_ready/result in, reset_occupied out) and every bus consumer (stations, register file, reorder logic).

## Interface
- SIZE, 32, result width in bits
- STATION_COUNT, 4, number of stations arbitrated; lane/station index i means station i
- STATION_INDEX_SIZE, 2, width of a station tag; 2^STATION_INDEX_SIZE >= STATION_COUNT
- BUS_COUNT, 1, number of bus lanes; 1 <= BUS_COUNT <= STATION_COUNT
- clock  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- station_ready  input  STATION_COUNT  bit i = station i result_ready
- station_result  input  SIZE*STATION_COUNT  flat; station i result at bits [i*SIZE +: SIZE]
- station_release  output  STATION_COUNT  bit i pulses one cycle; wired to station i reset_occupied
- bus_asserted  output  BUS_COUNT  lane k carries a valid result
- bus_source  output  STATION_INDEX_SIZE*BUS_COUNT  flat; lane k tag at [k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]
- bus_value  output  SIZE*BUS_COUNT  flat; lane k value at [k*SIZE +: SIZE]

## Operation
- Eligible(i) = station_ready[i] && !station_release[i]; a station released this cycle still shows ready (it drops occupied at the next edge) and must not be granted twice.
- Search order starts at pointer p, ascending, wrapping from STATION_COUNT-1 to 0; first BUS_COUNT eligible stations are granted, assigned to lanes 0,1,... in search order.
- Per granted lane k at edge: bus_asserted[k]<=1, bus_source[k]<=station index, bus_value[k]<=that station's result; station_release[index]<=1.
- Ungranted lanes: bus_asserted<=0, bus_source<=0, bus_value<=0. Non-granted release bits <=0.
- Pointer update: if any grant, p <= (last granted index + 1) wrapped modulo STATION_COUNT (explicit compare, not power-of-two mask); else p unchanged.
- Fewer eligible stations than lanes: only that many lanes asserted, lowest lanes first.
- No eligible station: all outputs deasserted, p held.
- A station that receives set_occupied in the same cycle its release is high keeps its new instruction (station side gives set priority); arbiter needs no special case.

## Timing
- Reset values: bus_asserted=0, bus_source=0, bus_value=0, station_release=0, p=0.
- Latency: station_ready high in cycle N (and eligible) -> bus lane and release asserted in cycle N+1, one cycle wide.
- Consumers sample the bus at the end of cycle N+1; station occupied falls at that same edge.
- Back-to-back: a station re-dispatched and ready again is eligible in cycle N+2 at earliest.
- Reset asserted mid-broadcast: at that edge all outputs clear and p returns to 0; an in-flight grant is dropped, the station stays occupied and is re-granted after reset deasserts.
- Throughput: up to BUS_COUNT results per cycle, sustained.

## Configuration
- RESULT_BUS_ROUND_ROBIN_EN defined: rotating pointer as above; any continuously ready station is granted within ceil(STATION_COUNT/BUS_COUNT) cycles.
- Not defined: p fixed at 0, no pointer register; strict priority to lowest index (starvation of high indices permitted).

## Test plan
- Reset: hold reset 2 cycles with station_ready=4'b1111 -> all outputs 0 during and the cycle after reset deasserts; first grant station 0 one cycle later.
- Single ready: STATION_COUNT=4, BUS_COUNT=1, station 2 ready with result 0xDEADBEEF in cycle N -> cycle N+1 bus_asserted=1, bus_source=2, bus_value=0xDEADBEEF, station_release=4'b0100; station 2 not regranted in N+1.
- Round robin (macro on): stations 0,1,3 held ready, each releases-then-re-dispatches immediately -> grant order 0,1,3,0,1,3; with macro off -> order 0,1,0,1 (station 1 only when 0 is masked), 3 starves.
- Wrap: p=3, stations 0 and 3 ready -> grant 3, then p=0, grant 0, then p=1.
- Two lanes: BUS_COUNT=2, stations 1,2,3 ready from p=0 -> lane0=1, lane1=2, release=4'b0110; next cycle lane0=3, lane1 deasserted.
- Reset mid-broadcast: reset in cycle of station 1 grant -> outputs 0 next cycle, station 1 granted again after reset deasserts with its held result.
